// File: rtl/r4u4_two_ctrl_pkg.sv
// Shared constants, types and helpers for the radix-4 unit 4 stage-two buffer controller.
package r4u4_two_ctrl_pkg;

  localparam int MAN_WIDTH = 16;
  localparam int EXP_WIDTH = 6;
  localparam int DW        = 2 * MAN_WIDTH + EXP_WIDTH;
  localparam int AW        = 9;
  localparam int MAX_Q     = 128;
  localparam int KW        = 7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN
  } state_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [1:0]    leg;
    logic [KW-1:0] k;
    logic          last;
  } entry_t;

  // Quarter length actually used for a block: 0 means 1, anything above the RAM limit clamps.
  function automatic logic [7:0] resolve_m(input logic [7:0] len);
    if (len == 8'd0) return 8'd1;
    if (len > 8'(MAX_Q)) return 8'(MAX_Q);
    return len;
  endfunction

endpackage

// File: rtl/r4u4_two_ctrl_if.sv
// Stream and RAM-port bundle between the stage-two controller and its surroundings.
interface r4u4_two_ctrl_if;
  import r4u4_two_ctrl_pkg::*;

  logic [7:0]    len_quarter;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    out_leg;
  logic [KW-1:0] out_k;
  logic          out_last;
  logic          ram_wr_en;
  logic [AW-1:0] ram_wr_addr;
  logic [DW-1:0] ram_wr_data;
  logic [AW-1:0] ram_rd_addr;
  logic [DW-1:0] ram_rd_data;

  modport master (
    input  len_quarter, in_valid, in_data, out_ready, ram_rd_data,
    output in_ready, out_valid, out_data, out_leg, out_k, out_last,
           ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_addr
  );

  modport slave (
    output len_quarter, in_valid, in_data, out_ready, ram_rd_data,
    input  in_ready, out_valid, out_data, out_leg, out_k, out_last,
           ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_addr
  );

endinterface

// File: rtl/r4u4_out_fifo2.sv
// Two-entry valid/ready output FIFO carrying a sample with its butterfly tag; head is registered.
module r4u4_out_fifo2
  import r4u4_two_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  entry_t     push_entry,
  input  logic       pop_ready,
  output logic       head_valid,
  output entry_t     head,
  output logic       pop,
  output logic [1:0] cnt
);

  entry_t     slot1;
  logic [1:0] cnt_q;

  assign head_valid = (cnt_q != 2'd0);
  assign pop        = head_valid & pop_ready;
  assign cnt        = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 2'd0;
      head  <= '0;
    end else begin
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
      // On a pop the second slot moves up; otherwise the head only loads when empty.
      if (pop) begin
        head <= (cnt_q == 2'd2) ? slot1 : push_entry;
      end else if (push && cnt_q == 2'd0) begin
        head <= push_entry;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && ((cnt_q == 2'd1 && !pop) || (cnt_q == 2'd2 && pop))) begin
      slot1 <= push_entry;
    end
  end

endmodule

// File: rtl/r4u4_two_ctrl.sv
// Stage-two buffer controller: natural-order block write, then radix-4 butterfly-order read.
module r4u4_two_ctrl
  import r4u4_two_ctrl_pkg::*;
(
  input  logic            clk_sys,
  input  logic            rst_sys,
  r4u4_two_ctrl_if.master bus
);

  state_t        state, state_nxt;
  logic [7:0]    m_q;
  logic [AW-1:0] wr_cnt;
  logic [KW-1:0] k;
  logic [1:0]    leg;
  logic [AW-1:0] leg_off;

  logic          in_ready_c;
  logic          accept;
  logic [9:0]    wr_last_addr;
  logic          wr_last;
  logic [2:0]    occ;
  logic          issue_p0;
  logic          rd_last_p0;

  logic          vld_p1;
  logic [1:0]    leg_p1;
  logic [KW-1:0] k_p1;
  logic          last_p1;

  entry_t        push_entry;
  entry_t        head;
  logic          head_valid;
  logic          pop;
  logic [1:0]    fifo_cnt;

  assign in_ready_c   = (state == ST_IDLE) || (state == ST_WRITE);
  assign accept       = bus.in_valid & in_ready_c;
  assign wr_last_addr = {m_q, 2'b00} - 10'd1;
  assign wr_last      = ({1'b0, wr_cnt} == wr_last_addr);

  // Occupancy the FIFO will have once this cycle's pop and the pending RAM return settle.
  assign occ        = {1'b0, fifo_cnt} + {2'b00, vld_p1} - {2'b00, pop};
  assign issue_p0   = (state == ST_READ) && (occ < 3'd2);
  assign rd_last_p0 = (leg == 2'd3) && ({1'b0, k} == m_q - 8'd1);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_WRITE;
      ST_WRITE: if (accept && wr_last) state_nxt = ST_READ;
      ST_READ:  if (issue_p0 && rd_last_p0) state_nxt = ST_DRAIN;
      ST_DRAIN: if (occ == 3'd0) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      state   <= ST_IDLE;
      m_q     <= 8'd0;
      wr_cnt  <= '0;
      k       <= '0;
      leg     <= 2'd0;
      leg_off <= '0;
      vld_p1  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && accept) begin
        m_q    <= resolve_m(bus.len_quarter);
        wr_cnt <= AW'(1);
      end else if (state == ST_WRITE && accept) begin
        wr_cnt <= wr_last ? '0 : wr_cnt + AW'(1);
      end
      // Leg offset steps by M per leg so the address is leg*M + k without a multiplier.
      if (issue_p0) begin
        if (leg == 2'd3) begin
          leg     <= 2'd0;
          leg_off <= '0;
          k       <= rd_last_p0 ? '0 : k + 7'd1;
        end else begin
          leg     <= leg + 2'd1;
          leg_off <= leg_off + {1'b0, m_q};
        end
      end
      vld_p1 <= issue_p0;
    end
  end

  // p0 -> p1: tag travels alongside the RAM's registered read.
  always_ff @(posedge clk_sys) begin
    leg_p1  <= leg;
    k_p1    <= k;
    last_p1 <= rd_last_p0;
  end

  assign push_entry = '{data: bus.ram_rd_data, leg: leg_p1, k: k_p1, last: last_p1};

  r4u4_out_fifo2 u_out_fifo (
    .clk        (clk_sys),
    .rst        (rst_sys),
    .push       (vld_p1),
    .push_entry (push_entry),
    .pop_ready  (bus.out_ready),
    .head_valid (head_valid),
    .head       (head),
    .pop        (pop),
    .cnt        (fifo_cnt)
  );

  assign bus.in_ready    = in_ready_c;
  assign bus.out_valid   = head_valid;
  assign bus.out_data    = head.data;
  assign bus.out_leg     = head.leg;
  assign bus.out_k       = head.k;
  assign bus.out_last    = head.last;
  assign bus.ram_wr_en   = ~accept;
  assign bus.ram_wr_addr = wr_cnt;
  assign bus.ram_wr_data = bus.in_data;
  assign bus.ram_rd_addr = leg_off + {2'b00, k};

endmodule

// File: tb/tb_r4u4_two_ctrl.sv
// Self-checking bench for r4u4_two_ctrl with a behavioural stage-two RAM and butterfly-order model.
module tb_r4u4_two_ctrl;
  import r4u4_two_ctrl_pkg::*;

  logic clk_sys = 1'b0;
  logic rst_sys;
  always #5 clk_sys = ~clk_sys;

  r4u4_two_ctrl_if bus();

  r4u4_two_ctrl dut (
    .clk_sys (clk_sys),
    .rst_sys (rst_sys),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem [0:511];
  always @(posedge clk_sys) begin
    if (!bus.ram_wr_en) mem[bus.ram_wr_addr] <= bus.ram_wr_data;
    bus.ram_rd_data <= mem[bus.ram_rd_addr];
  end

  typedef struct {
    int len;
    int pct;
    int exp_m;
    int exp_busy;
    bit rnd;
  } vec_t;

  vec_t          vecs [7];
  logic [DW-1:0] blk [$];
  logic [DW-1:0] got [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_word();
    logic [31:0] a, b;
    logic [63:0] w;
    a = $urandom;
    b = $urandom;
    w = {a, b};
    return w[DW-1:0];
  endfunction

  function automatic int ref_m(input int len);
    if (len == 0) return 1;
    if (len > MAX_Q) return MAX_Q;
    return len;
  endfunction

  task automatic write_block(input int len, input int m, input bit rnd);
    int n;
    int idx;
    int cyc;
    n = 4 * m;
    idx = 0;
    cyc = 0;
    blk.delete();
    for (int i = 0; i < n; i++) blk.push_back(rnd ? rnd_word() : DW'(i));
    while (idx < n && cyc < 8 * n + 40) begin
      @(posedge clk_sys); #1;
      bus.in_valid    = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.in_data     = blk[idx];
      bus.len_quarter = (idx == 0) ? 8'(len) : 8'($urandom_range(0, 255));
      bus.out_ready   = 1'b1;
      #1;
      if (bus.in_valid && bus.in_ready) begin
        chk("wr_en_active", 64'(bus.ram_wr_en), 0);
        chk("wr_addr", 64'(bus.ram_wr_addr), 64'(idx));
        chk("wr_data", 64'(bus.ram_wr_data), 64'(blk[idx]));
        idx++;
      end else begin
        chk("wr_en_inactive", 64'(bus.ram_wr_en), 1);
      end
      cyc++;
    end
    if (idx < n) chk("write_timeout", 64'(idx), 64'(n));
  endtask

  task automatic read_block(input int m, input int pct, input int exp_busy, input int stop_after);
    logic [DW-1:0] eq_d [$];
    int            eq_leg [$];
    int            eq_k [$];
    bit            eq_last [$];
    int            busy;
    int            first;
    int            pops;
    bit            done;
    busy = 0;
    first = -1;
    pops = 0;
    done = 1'b0;
    for (int kk = 0; kk < m; kk++) begin
      for (int lg = 0; lg < 4; lg++) begin
        eq_d.push_back(blk[lg * m + kk]);
        eq_leg.push_back(lg);
        eq_k.push_back(kk);
        eq_last.push_back((kk == m - 1) && (lg == 3));
      end
    end
    got.delete();
    for (int cyc = 0; cyc < 16 * m + 40; cyc++) begin
      @(posedge clk_sys); #1;
      bus.out_ready   = ($urandom_range(0, 99) < pct);
      bus.in_valid    = 1'($urandom_range(0, 1));
      bus.in_data     = rnd_word();
      bus.len_quarter = 8'($urandom_range(0, 255));
      #1;
      if (bus.in_ready) begin
        bus.in_valid = 1'b0;
        done = 1'b1;
        break;
      end
      busy++;
      chk("wr_en_during_read", 64'(bus.ram_wr_en), 1);
      if (bus.out_valid && first < 0) begin
        first = cyc;
        chk("first_out_latency", 64'(cyc), 2);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (eq_d.size() == 0) begin
          chk("extra_output", 1, 0);
        end else begin
          chk("out_data", 64'(bus.out_data), 64'(eq_d.pop_front()));
          chk("out_leg", 64'(bus.out_leg), 64'(eq_leg.pop_front()));
          chk("out_k", 64'(bus.out_k), 64'(eq_k.pop_front()));
          chk("out_last", 64'(bus.out_last), 64'(eq_last.pop_front()));
          got.push_back(bus.out_data);
        end
        pops++;
        if (stop_after > 0 && pops == stop_after) return;
      end
    end
    chk("read_done", 64'(done), 1);
    chk("outputs_left", 64'(eq_d.size()), 0);
    if (exp_busy >= 0) chk("in_ready_low_cycles", 64'(busy), 64'(exp_busy));
  endtask

  initial begin
    int exp3 [12];
    int exp2 [8];
    int len;
    int m;
    int pct;
    exp3 = '{0, 3, 6, 9, 1, 4, 7, 10, 2, 5, 8, 11};
    exp2 = '{0, 2, 4, 6, 1, 3, 5, 7};

    vecs[0] = '{1,   100, 1,   6,   1'b0};
    vecs[1] = '{3,   100, 3,   14,  1'b0};
    vecs[2] = '{128, 100, 128, 514, 1'b0};
    vecs[3] = '{16,  50,  16,  -1,  1'b1};
    vecs[4] = '{0,   100, 1,   6,   1'b1};
    vecs[5] = '{200, 100, 128, 514, 1'b1};
    vecs[6] = '{7,   30,  7,   -1,  1'b1};

    bus.len_quarter = 8'd0;
    bus.in_valid    = 1'b0;
    bus.in_data     = '0;
    bus.out_ready   = 1'b0;
    rst_sys = 1'b1;
    repeat (3) @(posedge clk_sys);
    #1 rst_sys = 1'b0;
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 1);
    chk("rst_out_valid", 64'(bus.out_valid), 0);
    chk("rst_out_last", 64'(bus.out_last), 0);
    chk("rst_out_leg", 64'(bus.out_leg), 0);
    chk("rst_out_k", 64'(bus.out_k), 0);
    chk("rst_out_data", 64'(bus.out_data), 0);
    chk("rst_wr_en", 64'(bus.ram_wr_en), 1);
    chk("rst_rd_addr", 64'(bus.ram_rd_addr), 0);

    for (int i = 0; i < 7; i++) begin
      write_block(vecs[i].len, vecs[i].exp_m, vecs[i].rnd);
      read_block(vecs[i].exp_m, vecs[i].pct, vecs[i].exp_busy, 0);
      if (i == 1) begin
        chk("m3_count", 64'(got.size()), 12);
        if (got.size() == 12)
          for (int j = 0; j < 12; j++) chk("m3_order", 64'(got[j]), 64'(exp3[j]));
      end
    end

    for (int r = 0; r < 4; r++) begin
      len = $urandom_range(0, 255);
      m   = ref_m(len);
      pct = $urandom_range(20, 100);
      write_block(len, m, 1'b1);
      read_block(m, pct, (pct == 100) ? 4 * m + 2 : -1, 0);
    end

    // Abort a block in READ after five outputs, then run a clean M=2 block.
    write_block(4, 4, 1'b0);
    read_block(4, 100, -1, 5);
    @(posedge clk_sys); #1;
    bus.in_valid = 1'b0;
    rst_sys = 1'b1;
    @(posedge clk_sys); #1;
    rst_sys = 1'b0;
    #1;
    chk("abort_out_valid", 64'(bus.out_valid), 0);
    chk("abort_in_ready", 64'(bus.in_ready), 1);
    chk("abort_wr_en", 64'(bus.ram_wr_en), 1);
    chk("abort_out_last", 64'(bus.out_last), 0);
    chk("abort_rd_addr", 64'(bus.ram_rd_addr), 0);
    write_block(2, 2, 1'b0);
    read_block(2, 100, 10, 0);
    chk("m2_count", 64'(got.size()), 8);
    if (got.size() == 8)
      for (int j = 0; j < 8; j++) chk("m2_order", 64'(got[j]), 64'(exp2[j]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/r4u4_two_ctrl.md
Name: r4u4_two_ctrl

Overview:
- Buffer controller for stage two of pipeline FFT radix-4 unit 4.
- Writes one block of N = 4*M complex block-floating-point samples into the 512-entry stage-two RAM in natural order.
- Then reads the block back in radix-4 butterfly order (k, k+M, k+2M, k+3M) and streams it to the stage-two butterfly.
- Owns the RAM write/read ports and provides valid/ready handshakes on both stream sides.

Parameters:
- DW, `MAN_WIDTH+`MAN_WIDTH+`EXP_WIDTH: sample word width ({man_re, man_im, exp}), passed through unmodified.
- AW, 9: RAM address width.
- MAX_Q, 128: maximum quarter length M (4*MAX_Q = 512 = RAM depth).

Ports:
- clk_sys  in  1  system clock.
- rst_sys  in  1  synchronous, active-high reset.
- len_quarter  in  8  quarter block length M; sampled on the first accepted sample of a block.
- in_valid  in  1  input sample valid.
- in_ready  out  1  controller accepts input.
- in_data  in  DW  input sample.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts output.
- out_data  out  DW  output sample.
- out_leg  out  2  butterfly leg 0..3 of out_data.
- out_k  out  7  butterfly index k (0..M-1).
- out_last  out  1  last sample of block (k=M-1, leg=3).
- ram_wr_en  out  1  RAM write enable, active low.
- ram_wr_addr  out  AW  RAM write address.
- ram_wr_data  out  DW  RAM write data (= in_data).
- ram_rd_addr  out  AW  RAM read address.
- ram_rd_data  in  DW  RAM read data, registered in RAM (valid one cycle after address).

Behaviour:
- Reset values:
  - state IDLE; all counters 0; FIFO empty; in-flight 0.
  - in_ready=1, out_valid=0, out_last=0, out_leg=0, out_k=0, out_data=0.
  - ram_wr_en=1 (inactive), ram_rd_addr=0.
- Reset mid-operation aborts the block; stale RAM contents are don't-care.
- M resolution at block start: 0 -> 1; >128 -> 128; otherwise as given. Latched as m_q; later len_quarter changes are ignored until the next block.
- States:
  - IDLE:
    - in_ready=1.
    - An accepted sample (in_valid&in_ready) latches m_q, writes address 0, sets wr_cnt=1.
    - Goes to WRITE, or straight to READ if 4*m_q==1 is impossible; with m_q=1 it goes to WRITE.
  - WRITE:
    - in_ready=1.
    - Each accept writes address wr_cnt, then wr_cnt++.
    - On the accept with wr_cnt==4*m_q-1, goes to READ.
  - READ:
    - in_ready=0.
    - Issues a read when (fifo_cnt + inflight) < 2.
    - Address = leg_off + k, where leg_off accumulates +m_q per leg (no multiplier).
    - Sequence: leg 0..3 for each k; k increments after leg 3.
    - After issuing (k=m_q-1, leg=3), goes to DRAIN.
  - DRAIN:
    - in_ready=0.
    - When FIFO is empty and inflight==0 (last sample accepted downstream), goes to IDLE; in_ready=1 the following cycle.
- Writes: ram_wr_en = ~(in_valid & in_ready), combinational. ram_wr_addr = current write count. ram_wr_data = in_data.
- Read pipeline:
  - Address issued in cycle t; ram_rd_data captured into the 2-entry output FIFO at the end of t+1, together with a leg/k/last tag pipelined alongside.
  - out_valid can first rise in cycle t+2 (2 cycles after entering READ).
- Output FIFO:
  - 2 entries, registered outputs.
  - Pop on out_valid&out_ready. Simultaneous push and pop allowed.
  - The credit rule guarantees no overflow, so no sample is lost or duplicated under any out_ready pattern.
  - Full throughput is 1 sample/cycle when out_ready stays high.
- Write and read never overlap: one RAM, half-duplex per block.
- Block cycle time without stalls: 4M writes + 4M reads + 2 cycles.

Decomposition:
- Shared package/include (fixed_point.v / macros.v): sample width macros (MAN_WIDTH, EXP_WIDTH), RAM depth/AW constants, FSM state encodings.
- One natural sub-module: r4u4_out_fifo2, a 2-entry valid/ready FIFO with data and tag, instantiated once.
- The RAM (r4u4_two_ram) is instantiated by the parent, not inside this block.

Test Plan:
- M=1, inputs D0..D3, out_ready=1 -> outputs D0,D1,D2,D3 with legs 0,1,2,3, k=0, out_last only on D3; in_ready low for 6 cycles.
- M=3, inputs 0..11 -> output order 0,3,6,9,1,4,7,10,2,5,8,11; k=0,0,0,0,1,...; out_last on 11.
- M=128, inputs 0..511 -> write addresses 0..511; last read address 511; 512 outputs, last = 511; no gaps with out_ready=1.
- M=16 with out_ready toggled pseudo-randomly (50%) -> all 64 outputs in butterfly order, no loss or duplication; FIFO never pushes while full.
- len_quarter=0 -> block of 4; len_quarter=200 -> block of 512; len_quarter changed mid-WRITE -> ignored.
- rst_sys asserted in READ after 5 outputs -> next cycle out_valid=0, in_ready=1, ram_wr_en=1; following M=2 block outputs 0,2,4,6,1,3,5,7 correctly.
